div_unit: RTL and testbench

Iterative multi-cycle integer divider for the MIPS246 execute stage, servicing DIV and DIVU. It is the inverse companion of the carry-lookahead add path: each cycle performs one restoring subtract/compare step and produces one quotient bit. Results feed the HI (remainder) and LO (quotient) registers. The pipeline stalls on `busy` while a division is in progress.

---
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU.
// One quotient bit per cycle; LO = quotient, HI = remainder.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;     // partial remainder
    logic [WIDTH-1:0] dvd_q;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dsr_q;     // divisor magnitude
    logic [WIDTH-1:0] a_q;       // raw dividend, returned as remainder on divide by zero
    logic [CW-1:0]    cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             bzero_q;

    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH:0]   shifted_d;
    logic [WIDTH+1:0] trial_d;
    logic             trial_neg_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    // Operand magnitudes at capture time
    always_comb begin
        a_mag_d = a;
        b_mag_d = b;
        if (sign && a[WIDTH-1]) a_mag_d = -a;
        if (sign && b[WIDTH-1]) b_mag_d = -b;
    end

    // One restoring step: shift in next dividend bit, trial-subtract the divisor
    always_comb begin
        shifted_d   = {rem_q, dvd_q[WIDTH-1]};
        trial_d     = {1'b0, shifted_d} - {2'b00, dsr_q};
        trial_neg_d = trial_d[WIDTH+1];
        rem_d       = trial_neg_d ? WIDTH'(shifted_d) : WIDTH'(trial_d);
        dvd_d       = {dvd_q[WIDTH-2:0], ~trial_neg_d};
    end

    // Sign correction and divide-by-zero override for the final result
    always_comb begin
        q_fix_d = qneg_q ? -dvd_q : dvd_q;
        r_fix_d = rneg_q ? -rem_q : rem_q;
        if (bzero_q) begin
            q_fix_d = '1;
            r_fix_d = a_q;
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            bzero_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        dvd_q   <= a_mag_d;
                        dsr_q   <= b_mag_d;
                        rem_q   <= '0;
                        qneg_q  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_q  <= sign & a[WIDTH-1];
                        bzero_q <= (b == '0);
                        cnt_q   <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) state_q <= S_FIX;
                end
                S_FIX: begin
                    quotient  <= q_fix_d;
                    remainder <= r_fix_d;
                    div_zero  <= bzero_q;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed test of div_unit against a cycle-level arithmetic model.
module tb_div_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: truncating division, remainder follows dividend sign
    function automatic void ref_div(input logic s, input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    output logic [WIDTH-1:0] q,
                                    output logic [WIDTH-1:0] r,
                                    output logic dz);
        longint sx;
        longint sy;
        if (y == '0) begin
            q  = '1;
            r  = x;
            dz = 1'b1;
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = WIDTH'(sx / sy);
            r  = WIDTH'(sx % sy);
            dz = 1'b0;
        end else begin
            q  = x / y;
            r  = x % y;
            dz = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model state: remaining edges of the in-flight operation and expected outputs
    bit               m_valid = 1'b0;
    int               m_left  = 0;
    logic             m_done, m_dz, p_dz;
    logic [WIDTH-1:0] m_q, m_r, p_q, p_r;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_done  = 1'b0;
            m_q     = '0;
            m_r     = '0;
            m_dz    = 1'b0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                end
            end else if (start) begin
                ref_div(sign, a, b, p_q, p_r, p_dz);
                m_left = LAT;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", WIDTH'(busy), WIDTH'(m_left > 0));
            chk("done", WIDTH'(done), WIDTH'(m_done));
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_zero", WIDTH'(div_zero), WIDTH'(m_dz));
        end
    end

    task automatic issue(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1;
        sign  = s;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom);
    endtask

    // Wait for done, counting edges since the start edge; timeout is a failure
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for done, got none expected one", name);
        end
    endtask

    task automatic run(input string name, input logic s, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] eq,
                       input logic [WIDTH-1:0] er, input logic edz);
        int lat;
        issue(s, x, y);
        wait_done(name, lat);
        chk({name, " latency"}, WIDTH'(lat), WIDTH'(LAT));
        chk({name, " q"}, quotient, eq);
        chk({name, " r"}, remainder, er);
        chk({name, " dz"}, WIDTH'(div_zero), WIDTH'(edz));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", WIDTH'(busy), 0);
        chk("reset q", quotient, 0);
        rst = 1'b0;
        @(negedge clk);

        run("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run("divu ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run("divu big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        run("div0 s", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run("div0 u", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run("div0 neg", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
        run("clear dz", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Abort mid-calculation with reset; no done may follow
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", WIDTH'(busy), 0);
        chk("abort q", quotient, 0);
        chk("abort r", remainder, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort no done", WIDTH'(seen), 0);
        run("after abort 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Start while busy is ignored; start during done is taken back-to-back
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(1'b0, 32'd50, 32'd5);
        wait_done("ignored start", lat);
        chk("ignored latency", WIDTH'(lat + 5), WIDTH'(LAT));
        chk("ignored q", quotient, 32'd14);
        chk("ignored r", remainder, 32'd2);
        issue(1'b0, 32'd50, 32'd5);
        wait_done("b2b", lat);
        chk("b2b latency", WIDTH'(lat), WIDTH'(LAT));
        chk("b2b q", quotient, 32'd10);
        chk("b2b r", remainder, 32'd0);

        // Reset coinciding with start: reset wins
        rst = 1'b1;
        issue(1'b0, 32'd100, 32'd7);
        rst = 1'b0;
        chk("rst vs start busy", WIDTH'(busy), 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
